hdmi_422_out: RTL and testbench
===============================

Name: hdmi_422_out

Overview:
- Video output stage that drives the board's HDMI transmitter pins: hdmi_data[15:0], hdmi_data_e, hdmi_hsync and hdmi_vsync.
- Consumes a 24-bit YCbCr 4:4:4 pixel stream (AXI-Stream style, tuser = start of frame, tlast = end of line) from the display DMA.
- Runs a programmable video timing generator and decimates chroma to 16-bit 4:2:2.
- Locks the incoming stream to the timing, outputs black and reports errors on underflow or misalignment. hdmi_out_clk forwarding (ODDR) is outside this block.

Parameters:
H_ACTIVE, 1920, active pixels per line (even)
H_FP, 88, horizontal front porch, pixels
H_SYNC, 44, hsync width, pixels
H_BP, 148, horizontal back porch, pixels
V_ACTIVE, 1080, active lines per frame
V_FP, 4, vertical front porch, lines
V_SYNC, 5, vsync width, lines
V_BP, 36, vertical back porch, lines
SYNC_POL, 1, 1 = syncs active-high, 0 = active-low

Ports:
clk  input  1  pixel clock; all logic in this single domain
resetn  input  1  asynchronous active-low reset
enable  input  1  timing run enable
s_axis_tdata  input  24  [23:16] Cr, [15:8] Cb, [7:0] Y
s_axis_tvalid  input  1  pixel valid
s_axis_tready  output  1  pixel accepted when tvalid && tready
s_axis_tuser  input  1  first pixel of frame
s_axis_tlast  input  1  last pixel of line
hdmi_data  output  16  [15:8] chroma, [7:0] Y
hdmi_data_e  output  1  data enable
hdmi_hsync  output  1  horizontal sync
hdmi_vsync  output  1  vertical sync
locked  output  1  stream aligned to timing (RUN state)
underflow  output  1  1-cycle pulse, no pixel available in active region
sync_err  output  1  1-cycle pulse, tuser/tlast misaligned

Behaviour:
- Reset values, asynchronous on resetn low:
  - h_cnt = 0, v_cnt = 0, state = IDLE.
  - hdmi_data = 16'h8010 (black), hdmi_data_e = 0.
  - hdmi_hsync and hdmi_vsync at inactive level (~SYNC_POL).
  - s_axis_tready = 0, locked = 0, underflow = 0, sync_err = 0.
- Timing counters:
  - H_TOTAL = sum of the four H parameters; V_TOTAL = sum of the four V parameters.
  - h_cnt wraps H_TOTAL-1 → 0 and increments v_cnt; v_cnt wraps V_TOTAL-1 → 0.
  - Order within a line/frame: active, front porch, sync, back porch.
- Regions:
  - active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hsync when H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync when V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC, whole lines, transitions at h_cnt = 0.
- Output timing: all pin outputs are registered, 1 cycle after the counter state that produces them. data, data_e and the syncs stay mutually aligned.
- enable low: counters held at 0 and state forced to IDLE. Outputs go to their reset values on the next edge. Counting starts at (0,0) on the first cycle enable is sampled high.
- State machine (IDLE / WAIT_SOF / RUN):
  - IDLE → WAIT_SOF when enable = 1.
  - WAIT_SOF:
    - tready = !s_axis_tuser; beats without tuser are discarded.
    - A valid tuser beat is held (tready = 0).
    - Transition to RUN at h_cnt = H_TOTAL-1, v_cnt = V_TOTAL-1, so the held beat is consumed at (0,0).
    - Output is black with data_e still following timing.
  - RUN:
    - locked = 1; tready = active.
    - Missing tvalid in active region → black pixel output, underflow pulse, → WAIT_SOF.
    - Valid beat with tuser = 1 at (h,v) ≠ (0,0) → beat not consumed (tready forced 0), black output, sync_err pulse, → WAIT_SOF. The beat is then held as the new SOF.
    - Accepted beat where tlast ≠ (h_cnt == H_ACTIVE-1) → pixel still output, sync_err pulse, → WAIT_SOF.
    - Simultaneous underflow and sync_err are impossible; sync_err requires tvalid.
- 4:2:2 packing (accepted pixels):
  - Y passes through.
  - Chroma is Cb when h_cnt[0] = 0 and Cr when h_cnt[0] = 1, taken from the same beat (decimation, no filtering).
- Black = 16'h8010.
- Outside the active region: data_e = 0, hdmi_data = black.

Test Plan:
- Use reduced parameters throughout: H 8/2/2/2 (H_TOTAL 14), V 4/1/1/1 (V_TOTAL 7), SYNC_POL 1.
- Timing only, tvalid = 0: data_e high for 8 of every 14 cycles on lines 0–3. hsync high at h_cnt 10–11. vsync high for all 14 cycles of line 5. Period 98 cycles.
- Continuous valid frames, pixel n = {Cr = 8'hC0+n, Cb = 8'hB0+n, Y = n}: locked rises at first frame start. Output line 0 = B000, C101, B202, C303, B404, C505, B606, C707 (1-cycle latency). No error pulses.
- Upstream stall at line 2 pixel 3: underflow pulses once, that pixel shows 8010, locked drops. Relock on the next SOF at frame start; following frame is correct.
- tuser asserted at line 1 pixel 0: sync_err pulses, beat held with tready = 0, black until next (0,0). At (0,0) the held beat is output.
- tlast at pixel 5: sync_err pulses, pixel 5 output, then WAIT_SOF.
- resetn low mid-line: all outputs at reset values immediately (asynchronous). enable dropped then raised: first data_e 1 cycle after enable sampled high plus counter latency.

Source files
------------

// File: rtl/hdmi_422_out_if.sv
// Pixel stream bundle between the display DMA and the HDMI output stage.
// tuser marks the first pixel of a frame, tlast the last pixel of a line.
interface hdmi_422_out_if;
    logic [23:0] tdata;   // [23:16] Cr, [15:8] Cb, [7:0] Y
    logic        tvalid;
    logic        tready;
    logic        tuser;
    logic        tlast;

    modport master (output tdata, tvalid, tuser, tlast, input tready);
    modport slave  (input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/hdmi_422_out.sv
// HDMI output stage: programmable video timing, 4:4:4 -> 4:2:2 chroma
// decimation and stream-to-timing lock with underflow / misalignment recovery.
module hdmi_422_out #(
    parameter int H_ACTIVE = 1920,
    parameter int H_FP     = 88,
    parameter int H_SYNC   = 44,
    parameter int H_BP     = 148,
    parameter int V_ACTIVE = 1080,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 36,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          enable,
    hdmi_422_out_if.slave s_axis,
    output logic [15:0]   hdmi_data,
    output logic          hdmi_data_e,
    output logic          hdmi_hsync,
    output logic          hdmi_vsync,
    output logic          locked,
    output logic          underflow,
    output logic          sync_err
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] HS_BEG     = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG     = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [15:0] BLACK = 16'h8010;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_SOF = 2'd1;
    localparam logic [1:0] ST_RUN      = 2'd2;

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [1:0]    state_q, state_d;
    logic [15:0]   data_q, data_d;
    logic          de_q, hs_q, vs_q;
    logic          uf_q, uf_d, se_q, se_d;

    logic active, origin, line_end, frame_end, hsync_c, vsync_c;
    logic tready, pix_ok;

    assign active    = (h_q < H_ACT) && (v_q < V_ACT);
    assign origin    = (h_q == '0) && (v_q == '0);
    assign line_end  = (h_q == H_ACT_LAST);
    assign frame_end = (h_q == H_LAST) && (v_q == V_LAST);
    assign hsync_c   = (h_q >= HS_BEG) && (h_q < HS_END);
    assign vsync_c   = (v_q >= VS_BEG) && (v_q < VS_END);

    // Raster position advance: h wraps into v, v wraps at end of frame.
    always_comb begin
        h_d = h_q + HW'(1);
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
        end
    end

    // Lock state machine, stream acceptance and 4:2:2 pixel selection.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d = state_q;
        tready  = 1'b0;
        pix_ok  = 1'b0;
        uf_d    = 1'b0;
        se_d    = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_WAIT_SOF;
            ST_WAIT_SOF: begin
                // Drain stale beats; a start-of-frame beat is held until (0,0).
                tready = !s_axis.tuser;
                if (frame_end && s_axis.tvalid && s_axis.tuser)
                    state_d = ST_RUN;
            end
            ST_RUN: begin
                // An early start-of-frame is refused so it can become the next SOF.
                tready = active && !(s_axis.tuser && !origin);
                if (active) begin
                    if (!s_axis.tvalid) begin
                        uf_d    = 1'b1;
                        state_d = ST_WAIT_SOF;
                    end else if (!tready) begin
                        se_d    = 1'b1;
                        state_d = ST_WAIT_SOF;
                    end else begin
                        pix_ok = 1'b1;
                        if (s_axis.tlast != line_end) begin
                            se_d    = 1'b1;
                            state_d = ST_WAIT_SOF;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Even columns carry Cb, odd columns Cr, both from the pixel's own beat.
        data_d = pix_ok ? {(h_q[0] ? s_axis.tdata[23:16] : s_axis.tdata[15:8]),
                           s_axis.tdata[7:0]}
                        : BLACK;
    end

    // Registered state and pins; enable low parks everything at reset values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            h_q     <= '0;
            v_q     <= '0;
            state_q <= ST_IDLE;
            data_q  <= BLACK;
            de_q    <= 1'b0;
            hs_q    <= ~SYNC_POL;
            vs_q    <= ~SYNC_POL;
            uf_q    <= 1'b0;
            se_q    <= 1'b0;
        end else if (!enable) begin
            h_q     <= '0;
            v_q     <= '0;
            state_q <= ST_IDLE;
            data_q  <= BLACK;
            de_q    <= 1'b0;
            hs_q    <= ~SYNC_POL;
            vs_q    <= ~SYNC_POL;
            uf_q    <= 1'b0;
            se_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            h_q     <= h_d;
            v_q     <= v_d;
            state_q <= state_d;
            data_q  <= data_d;
            de_q    <= active;
            hs_q    <= hsync_c ? SYNC_POL : ~SYNC_POL;
            vs_q    <= vsync_c ? SYNC_POL : ~SYNC_POL;
            uf_q    <= uf_d;
            se_q    <= se_d;
        end
    end

    assign s_axis.tready = tready && enable;
    assign hdmi_data     = data_q;
    assign hdmi_data_e   = de_q;
    assign hdmi_hsync    = hs_q;
    assign hdmi_vsync    = vs_q;
    assign underflow     = uf_q;
    assign sync_err      = se_q;
    assign locked        = (state_q == ST_RUN);
endmodule

// File: tb/tb_hdmi_422_out.sv
// Directed bench for hdmi_422_out with a reduced 14x7 raster (98 cycles/frame).
module tb_hdmi_422_out;
    localparam int FRAME = 98;

    typedef enum {M_NONE, M_STALL, M_RESTART, M_TLAST} mode_t;
    typedef struct {
        int          n;      // cycles after the first enabled edge
        logic        de;
        logic        hs;
        logic        vs;
        logic [15:0] data;
    } vec_t;

    logic        clk = 1'b0;
    logic        resetn, enable;
    logic [15:0] hdmi_data;
    logic        hdmi_data_e, hdmi_hsync, hdmi_vsync, locked, underflow, sync_err;

    hdmi_422_out_if axis();

    hdmi_422_out #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1)
    ) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .s_axis(axis),
        .hdmi_data(hdmi_data), .hdmi_data_e(hdmi_data_e), .hdmi_hsync(hdmi_hsync),
        .hdmi_vsync(hdmi_vsync), .locked(locked), .underflow(underflow), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    int    n_tests = 0, n_fail = 0;
    int    edges = 0;
    int    de_cnt = 0, hs_cnt = 0, vs_cnt = 0, uf_cnt = 0, se_cnt = 0;
    logic  src_on = 1'b0;
    mode_t mode = M_NONE;
    logic  fire = 1'b0;
    int    sl = 0, sp = 0;
    logic  stall;

    // Enabled edges since counting restarted; pos = edges-1 is the raster point shown at the next negedge.
    always @(posedge clk) begin
        if (resetn && enable) edges = edges + 1;
        else                  edges = 0;
    end

    always @(negedge clk) fire = axis.tvalid && axis.tready;

    // DMA model: line sl, pixel sp; Cr=C0+sp, Cb=B0+sp, Y={line,pixel}.
    always @(posedge clk) begin
        #1;
        if (!src_on) begin
            sl = 0;
            sp = 0;
        end else if (fire) begin
            sp = sp + 1;
            if (sp == 8) begin
                sp = 0;
                sl = sl + 1;
                if (sl == 4) sl = 0;
                if (mode == M_RESTART && sl == 1) sl = 0;
            end
        end
        stall        = src_on && mode == M_STALL && sl == 2 && sp == 3;
        axis.tvalid  = src_on && !stall;
        axis.tuser   = src_on && sl == 0 && sp == 0;
        axis.tlast   = src_on && (sp == 7 || (mode == M_TLAST && sl == 1 && sp == 5));
        axis.tdata   = src_on ? {8'(8'hC0 + sp), 8'(8'hB0 + sp), 8'(sl * 16 + sp)} : 24'h0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        de_cnt += int'(hdmi_data_e);
        hs_cnt += int'(hdmi_hsync);
        vs_cnt += int'(hdmi_vsync);
        uf_cnt += int'(underflow);
        se_cnt += int'(sync_err);
    endtask

    task automatic goto_abs(input int n);
        int guard = 0;
        do begin tick(); guard++; end while (edges - 1 != n && guard < 400);
        if (guard >= 400) begin
            n_tests++; n_fail++;
            $display("FAIL goto_abs timeout: target %0d, at %0d", n, edges - 1);
        end
    endtask

    task automatic goto(input int pos);
        int guard = 0;
        do begin tick(); guard++; end
        while (!(edges >= 1 && (edges - 1) % FRAME == pos) && guard < 300);
        if (guard >= 300) begin
            n_tests++; n_fail++;
            $display("FAIL goto timeout: target pos %0d", pos);
        end
    endtask

    vec_t        tab[16];
    logic [15:0] line0[8];
    int          s_de, s_hs, s_vs, s_uf, s_se;

    initial begin
        tab[0]  = '{0,   1'b1, 1'b0, 1'b0, 16'h8010};
        tab[1]  = '{7,   1'b1, 1'b0, 1'b0, 16'h8010};
        tab[2]  = '{8,   1'b0, 1'b0, 1'b0, 16'h8010};
        tab[3]  = '{9,   1'b0, 1'b0, 1'b0, 16'h8010};
        tab[4]  = '{10,  1'b0, 1'b1, 1'b0, 16'h8010};
        tab[5]  = '{11,  1'b0, 1'b1, 1'b0, 16'h8010};
        tab[6]  = '{12,  1'b0, 1'b0, 1'b0, 16'h8010};
        tab[7]  = '{49,  1'b1, 1'b0, 1'b0, 16'h8010};
        tab[8]  = '{56,  1'b0, 1'b0, 1'b0, 16'h8010};
        tab[9]  = '{70,  1'b0, 1'b0, 1'b1, 16'h8010};
        tab[10] = '{80,  1'b0, 1'b1, 1'b1, 16'h8010};
        tab[11] = '{83,  1'b0, 1'b0, 1'b1, 16'h8010};
        tab[12] = '{84,  1'b0, 1'b0, 1'b0, 16'h8010};
        tab[13] = '{98,  1'b1, 1'b0, 1'b0, 16'h8010};
        tab[14] = '{105, 1'b1, 1'b0, 1'b0, 16'h8010};
        tab[15] = '{106, 1'b0, 1'b0, 1'b0, 16'h8010};
        line0 = '{16'hB000, 16'hC101, 16'hB202, 16'hC303,
                  16'hB404, 16'hC505, 16'hB606, 16'hC707};

        // Reset state
        resetn = 1'b0;
        enable = 1'b0;
        repeat (3) tick();
        check("rst data", 32'(hdmi_data), 32'h8010);
        check("rst de", 32'(hdmi_data_e), 0);
        check("rst hsync", 32'(hdmi_hsync), 0);
        check("rst vsync", 32'(hdmi_vsync), 0);
        check("rst tready", 32'(axis.tready), 0);
        check("rst locked", 32'(locked), 0);
        check("rst underflow", 32'(underflow), 0);
        check("rst sync_err", 32'(sync_err), 0);
        @(posedge clk); #1 resetn = 1'b1;
        repeat (2) tick();
        @(posedge clk); #1 enable = 1'b1;

        // Timing only, no stream
        s_de = de_cnt; s_hs = hs_cnt; s_vs = vs_cnt; s_uf = uf_cnt; s_se = se_cnt;
        for (int i = 0; i < 16; i++) begin
            goto_abs(tab[i].n);
            check($sformatf("timing de @%0d", tab[i].n), 32'(hdmi_data_e), 32'(tab[i].de));
            check($sformatf("timing hs @%0d", tab[i].n), 32'(hdmi_hsync), 32'(tab[i].hs));
            check($sformatf("timing vs @%0d", tab[i].n), 32'(hdmi_vsync), 32'(tab[i].vs));
            check($sformatf("timing data @%0d", tab[i].n), 32'(hdmi_data), 32'(tab[i].data));
        end
        check("wait_sof tready", 32'(axis.tready), 1);
        check("wait_sof locked", 32'(locked), 0);
        goto_abs(111);
        check("de count", 32'(de_cnt - s_de), 40);
        check("hs count", 32'(hs_cnt - s_hs), 16);
        check("vs count", 32'(vs_cnt - s_vs), 14);
        check("timing uf count", 32'(uf_cnt - s_uf), 0);
        check("timing se count", 32'(se_cnt - s_se), 0);

        // Continuous frames
        src_on = 1'b1;
        goto(0);
        check("lock at sof", 32'(locked), 1);
        check("line0 px0", 32'(hdmi_data), 32'(line0[0]));
        check("line0 de", 32'(hdmi_data_e), 1);
        s_uf = uf_cnt; s_se = se_cnt;
        for (int h = 1; h < 8; h++) begin
            goto(h);
            check($sformatf("line0 px%0d", h), 32'(hdmi_data), 32'(line0[h]));
        end
        goto(14);
        check("line1 px0", 32'(hdmi_data), 32'h B010);
        goto(45);
        check("line3 px3", 32'(hdmi_data), 32'hC333);
        goto(97);
        check("run uf count", 32'(uf_cnt - s_uf), 0);
        check("run se count", 32'(se_cnt - s_se), 0);
        mode = M_STALL;

        // Upstream stall at line 2 pixel 3
        goto(30);
        check("pre-stall px", 32'(hdmi_data), 32'hB222);
        s_uf = uf_cnt; s_se = se_cnt;
        goto(31);
        check("stall data", 32'(hdmi_data), 32'h8010);
        check("stall underflow", 32'(underflow), 1);
        check("stall locked", 32'(locked), 0);
        goto(40);
        mode = M_NONE;
        goto(97);
        check("stall uf count", 32'(uf_cnt - s_uf), 1);
        check("stall se count", 32'(se_cnt - s_se), 0);
        goto(0);
        check("relock after stall", 32'(locked), 1);
        check("relock px0", 32'(hdmi_data), 32'hB000);
        goto(31);
        check("relock line2 px3", 32'(hdmi_data), 32'hC323);
        goto(60);
        mode = M_RESTART;

        // Early tuser at line 1 pixel 0
        goto(13);
        s_uf = uf_cnt; s_se = se_cnt;
        goto(14);
        check("tuser data", 32'(hdmi_data), 32'h8010);
        check("tuser sync_err", 32'(sync_err), 1);
        goto(20);
        check("tuser hold de", 32'(hdmi_data_e), 1);
        check("tuser hold data", 32'(hdmi_data), 32'h8010);
        check("tuser hold tready", 32'(axis.tready), 0);
        check("tuser hold locked", 32'(locked), 0);
        goto(30);
        mode = M_NONE;
        goto(97);
        check("tuser se count", 32'(se_cnt - s_se), 1);
        check("tuser uf count", 32'(uf_cnt - s_uf), 0);
        goto(0);
        check("held beat out", 32'(hdmi_data), 32'hB000);
        check("held beat locked", 32'(locked), 1);
        goto(14);
        check("after tuser line1", 32'(hdmi_data), 32'hB010);
        goto(60);
        mode = M_TLAST;

        // Early tlast at line 1 pixel 5
        goto(19);
        check("tlast data", 32'(hdmi_data), 32'hC515);
        check("tlast sync_err", 32'(sync_err), 1);
        goto(20);
        check("after tlast data", 32'(hdmi_data), 32'h8010);
        check("after tlast locked", 32'(locked), 0);
        goto(30);
        mode = M_NONE;
        goto(0);
        check("relock after tlast", 32'(locked), 1);
        check("relock tlast px0", 32'(hdmi_data), 32'hB000);
        goto(3);
        check("pre-reset px3", 32'(hdmi_data), 32'hC303);

        // Asynchronous reset mid-line
        #2 resetn = 1'b0;
        #1;
        check("async rst data", 32'(hdmi_data), 32'h8010);
        check("async rst de", 32'(hdmi_data_e), 0);
        check("async rst locked", 32'(locked), 0);
        check("async rst tready", 32'(axis.tready), 0);
        src_on = 1'b0;
        enable = 1'b0;
        @(posedge clk); #1 resetn = 1'b1;
        repeat (3) tick();
        check("disabled de", 32'(hdmi_data_e), 0);

        // Enable raised, then dropped
        @(posedge clk); #1 enable = 1'b1;
        tick();
        check("enable not yet sampled de", 32'(hdmi_data_e), 0);
        tick();
        check("first de after enable", 32'(hdmi_data_e), 1);
        goto(10);
        check("hsync after enable", 32'(hdmi_hsync), 1);
        @(posedge clk); #1 enable = 1'b0;
        tick();
        check("hsync before drop", 32'(hdmi_hsync), 1);
        tick();
        check("hsync after drop", 32'(hdmi_hsync), 0);
        check("de after drop", 32'(hdmi_data_e), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
